// File: rtl/fp_sub_normalizer_pkg.sv
// Shared definitions for the effective-subtraction normalize path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_sub_normalizer_pkg;

    localparam int DEF_MANT_BITS = 24;
    localparam int DEF_EXP_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fp_sub_normalizer_mant_abs_sub.sv
// Combinational |A-B| on aligned mantissas, A + ~B + 1 through a generate/propagate carry chain.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module mant_abs_sub #(
    parameter int W = 24
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_diff,
    output logic         o_borrow,
    output logic         o_is_zero
);

    logic [W-1:0] w_b_inv;
    logic [W-1:0] w_gen;
    logic [W-1:0] w_prop;
    logic [W-1:0] w_sum;
    logic         w_cout;

    assign w_b_inv = ~i_b;
    assign w_gen   = i_a & w_b_inv;
    assign w_prop  = i_a ^ w_b_inv;

    // Sum and carry-out of A + ~B with carry-in 1; carry-out 0 means B > A.
    always_comb begin : carry_chain
        logic c;
        c     = 1'b1;
        w_sum = '0;
        for (int i = 0; i < W; i++) begin
            w_sum[i] = w_prop[i] ^ c;
            c        = w_gen[i] | (w_prop[i] & c);
        end
        w_cout = c;
    end

    assign o_borrow  = ~w_cout;
    // Negative result is turned back into a magnitude by two's-complement negation.
    assign o_diff    = o_borrow ? (~w_sum + W'(1)) : w_sum;
    // A zero raw sum can only occur with A == B, so the negation path is never needed here.
    assign o_is_zero = (w_sum == '0);

endmodule

// File: rtl/fp_sub_normalizer.sv
// Mantissa subtract plus one-bit-per-cycle left normalize for the effective-subtraction path.
// Latency: 2 cycles for a zero result, k+3 for a nonzero result needing k shifts (max MANT_BITS+2).
// Backpressure: single operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fp_sub_normalizer
    import fp_sub_normalizer_pkg::*;
#(
    parameter int MANT_BITS = DEF_MANT_BITS,
    parameter int EXP_BITS  = DEF_EXP_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_BITS-1:0]  Exp_in,
    input  logic [MANT_BITS-1:0] A,
    input  logic [MANT_BITS-1:0] B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MANT_BITS-1:0] Mant_out,
    output logic [EXP_BITS-1:0]  Exp_out,
    output logic                 Sign_flip,
    output logic                 Zero,
    output logic                 Underflow
);

    state_t r_state;
    state_t w_state_nxt;

    // Working registers: latched operands, mantissa being shifted, exponent counter, sign.
    logic [MANT_BITS-1:0] r_a;
    logic [MANT_BITS-1:0] r_b;
    logic [MANT_BITS-1:0] r_mant;
    logic [EXP_BITS-1:0]  r_exp;
    logic                 r_sign;

    // Result registers presented to the rounding stage.
    logic                 r_out_valid;
    logic [MANT_BITS-1:0] r_mant_out;
    logic [EXP_BITS-1:0]  r_exp_out;
    logic                 r_sign_out;
    logic                 r_zero;
    logic                 r_underflow;

    logic [MANT_BITS-1:0] w_diff;
    logic                 w_borrow;
    logic                 w_is_zero;
    logic                 w_msb;
    logic                 w_exp_gt1;

    mant_abs_sub #(
        .W (MANT_BITS)
    ) u_abs_sub (
        .i_a       (r_a),
        .i_b       (r_b),
        .o_diff    (w_diff),
        .o_borrow  (w_borrow),
        .o_is_zero (w_is_zero)
    );

    assign w_msb     = r_mant[MANT_BITS-1];
    // Decrement only while above 1 so the exponent never wraps below the denormal boundary.
    assign w_exp_gt1 = (r_exp > EXP_BITS'(1));

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign Mant_out  = r_mant_out;
    assign Exp_out   = r_exp_out;
    assign Sign_flip = r_sign_out;
    assign Zero      = r_zero;
    assign Underflow = r_underflow;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (in_valid)                w_state_nxt = SUB;
            SUB:  w_state_nxt = w_is_zero ? DONE : NORM;
            NORM: if (w_msb || !w_exp_gt1)     w_state_nxt = DONE;
            DONE: if (out_ready)               w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, subtract, shift/decrement, and result registration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_mant      <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_out_valid <= 1'b0;
            r_mant_out  <= '0;
            r_exp_out   <= '0;
            r_sign_out  <= 1'b0;
            r_zero      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a   <= A;
                        r_b   <= B;
                        r_exp <= Exp_in;
                    end
                end
                SUB: begin
                    r_mant <= w_diff;
                    r_sign <= w_borrow;
                    if (w_is_zero) begin
                        r_out_valid <= 1'b1;
                        r_mant_out  <= '0;
                        r_exp_out   <= '0;
                        r_sign_out  <= 1'b0;
                        r_zero      <= 1'b1;
                        r_underflow <= 1'b0;
                    end
                end
                NORM: begin
                    if (w_msb) begin
                        r_out_valid <= 1'b1;
                        r_mant_out  <= r_mant;
                        r_exp_out   <= r_exp;
                        r_sign_out  <= r_sign;
                        r_zero      <= 1'b0;
                        r_underflow <= 1'b0;
                    end else if (w_exp_gt1) begin
                        r_mant <= {r_mant[MANT_BITS-2:0], 1'b0};
                        r_exp  <= r_exp - EXP_BITS'(1);
                    end else begin
                        // Denormal boundary: keep the mantissa as is and report exponent 0.
                        r_out_valid <= 1'b1;
                        r_mant_out  <= r_mant;
                        r_exp_out   <= '0;
                        r_sign_out  <= r_sign;
                        r_zero      <= 1'b0;
                        r_underflow <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sub_normalizer.sv
// Scoreboard bench for fp_sub_normalizer: model results queued at drive time, compared when out_valid rises.
// Latency: measured from the accepting edge, counting every occupied state cycle.
// Backpressure: exercised by holding out_ready low in DONE.
module tb_fp_sub_normalizer;

    localparam int MB = 24;
    localparam int EB = 8;

    typedef struct {
        logic [MB-1:0] mant;
        logic [EB-1:0] exp;
        logic          sgn;
        logic          zero;
        logic          uf;
        int            lat;
    } exp_t;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [EB-1:0] Exp_in    = '0;
    logic [MB-1:0] A         = '0;
    logic [MB-1:0] B         = '0;
    logic          in_ready;
    logic          out_valid;
    logic [MB-1:0] Mant_out;
    logic [EB-1:0] Exp_out;
    logic          Sign_flip;
    logic          Zero;
    logic          Underflow;

    int   n_cmp      = 0;
    int   n_err      = 0;
    int   cyc        = 0;
    int   acc_cyc    = 0;
    bit   prev_valid = 1'b0;
    exp_t q[$];
    exp_t mon_e;

    fp_sub_normalizer #(
        .MANT_BITS (MB),
        .EXP_BITS  (EB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Exp_in    (Exp_in),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Mant_out  (Mant_out),
        .Exp_out   (Exp_out),
        .Sign_flip (Sign_flip),
        .Zero      (Zero),
        .Underflow (Underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [MB-1:0] a, input logic [MB-1:0] b, input logic [EB-1:0] e);
        exp_t          r;
        logic [MB-1:0] m;
        logic [EB-1:0] x;
        int            k;
        r.sgn = (b > a);
        m     = (a >= b) ? a - b : b - a;
        if (m == '0) begin
            r.mant = '0; r.exp = '0; r.sgn = 1'b0; r.zero = 1'b1; r.uf = 1'b0; r.lat = 2;
            return r;
        end
        r.zero = 1'b0;
        x      = e;
        k      = 0;
        while (!m[MB-1] && x > 1) begin
            m = m << 1;
            x = x - 1;
            k++;
        end
        r.mant = m;
        if (m[MB-1]) begin
            r.exp = x;
            r.uf  = 1'b0;
        end else begin
            r.exp = '0;
            r.uf  = 1'b1;
        end
        r.lat = k + 3;
        return r;
    endfunction

    // Output monitor: pops the scoreboard on each rising out_valid.
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            if (q.size() == 0) begin
                check("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("mant",      32'(Mant_out),      32'(mon_e.mant));
                check("exp",       32'(Exp_out),       32'(mon_e.exp));
                check("sign_flip", 32'(Sign_flip),     32'(mon_e.sgn));
                check("zero",      32'(Zero),          32'(mon_e.zero));
                check("underflow", 32'(Underflow),     32'(mon_e.uf));
                check("latency",   32'(cyc - acc_cyc), 32'(mon_e.lat));
            end
        end
        prev_valid = out_valid;
    end

    task automatic run_op(input logic [MB-1:0] a, input logic [MB-1:0] b,
                          input logic [EB-1:0] e, input int hold);
        int            w;
        logic [MB-1:0] sm;
        logic [EB-1:0] se;
        logic [3:0]    sf;
        q.push_back(model(a, b, e));
        out_ready = (hold == 0);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        A = a; B = b; Exp_in = e; in_valid = 1'b1;
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) begin
            check("done_timeout", 32'(out_valid), 32'd1);
            q.delete();
            out_ready = 1'b1;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        if (hold > 0) begin
            sm = Mant_out; se = Exp_out; sf = {Sign_flip, Zero, Underflow, out_valid};
            A = ~a; B = b; Exp_in = ~e; in_valid = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                check("bp_mant",     32'(Mant_out), 32'(sm));
                check("bp_exp",      32'(Exp_out),  32'(se));
                check("bp_flags",    32'({Sign_flip, Zero, Underflow, out_valid}), 32'(sf));
                check("bp_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("post_hs_valid",    32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready),  32'd1);
    endtask

    initial begin
        logic [MB-1:0] ra;
        logic [MB-1:0] rb;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_mant",  32'(Mant_out),  32'd0);
        check("rst_flags", 32'({Exp_out, Sign_flip, Zero, Underflow}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed cases.
        run_op(24'hC00000, 24'h400000, 8'h80, 0);
        run_op(24'h800000, 24'h7FFFFF, 8'h7F, 0);
        run_op(24'h400000, 24'hC00000, 8'h10, 0);
        run_op(24'hABCDEF, 24'hABCDEF, 8'h55, 0);
        run_op(24'h800000, 24'h7FFFF0, 8'h05, 0);
        run_op(24'hC00000, 24'h400000, 8'h00, 0);
        run_op(24'h000010, 24'h000000, 8'h00, 0);
        run_op(24'h000003, 24'h000001, 8'h01, 0);
        run_op(24'h123456, 24'h923456, 8'hFF, 0);

        // Backpressure with new operands offered while DONE.
        run_op(24'h900000, 24'h0F0000, 8'h40, 5);

        // Random operands, including near-equal pairs for deep shifts.
        for (int i = 0; i < 8; i++) begin
            ra = MB'($urandom);
            rb = (i % 2 == 0) ? MB'($urandom) : (ra ^ MB'(1 << $urandom_range(0, MB - 1)));
            run_op(ra, rb, EB'($urandom_range(0, 255)), (i == 3) ? 2 : 0);
        end

        // Reset during NORM discards the operation.
        out_ready = 1'b1;
        @(negedge clk);
        A = 24'h800000; B = 24'h7FFFFF; Exp_in = 8'h7F; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid",    32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready),  32'd1);
        check("midrst_mant",     32'(Mant_out),  32'd0);
        check("midrst_flags",    32'({Exp_out, Sign_flip, Zero, Underflow}), 32'd0);
        repeat (30) @(negedge clk);
        check("midrst_no_output", 32'(out_valid), 32'd0);

        // Recovery after the aborted operation.
        run_op(24'hF00000, 24'h100000, 8'h22, 0);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
